decode_stage: RTL

- Registered, flow-controlled RV32/RV64 instruction decode stage between fetch and execute.
- Decodes each instruction in its accept cycle and pushes the result, with its PC, into a DEPTH-entry FIFO.
- Execute pops entries with a valid/ready handshake.
- Adds the following over the plain combinational decoder: XLEN-generic immediates, optional M-extension ops, RV64 word ops, an illegal-instruction flag, flush, and back-pressure buffering.

---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// valid/ready: a beat transfers on a rising clock edge where valid && ready; once valid is raised the payload holds until that edge.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_alu_op;
  logic            out_word;
  logic [10:0]     out_ctrl;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_imm, out_alu_op, out_word, out_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_imm, out_alu_op, out_word, out_ctrl, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32/RV64 decode stage: decodes on accept and buffers results with their PC in a DEPTH-entry FIFO.
// No FSM; occupancy lives in count, and outputs come straight from the head entry registers.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter bit HAS_M = 1'b0,
  parameter int DEPTH = 2
) (
  input logic           clock,
  input logic           reset,
  input logic           flush,
  decode_stage_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [10:0] C_PC    = 11'h400;
  localparam logic [10:0] C_IMM   = 11'h200;
  localparam logic [10:0] C_JALR  = 11'h100;
  localparam logic [10:0] C_JUMP  = 11'h080;
  localparam logic [10:0] C_BR    = 11'h040;
  localparam logic [10:0] C_BZ    = 11'h020;
  localparam logic [10:0] C_LOAD  = 11'h010;
  localparam logic [10:0] C_STORE = 11'h008;
  localparam logic [10:0] C_CSR   = 11'h004;
  localparam logic [10:0] C_CSRI  = 11'h002;
  localparam logic [10:0] C_CSRSC = 11'h001;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic            word;
    logic [10:0]     ctrl;
    logic            illegal;
  } entry_t;

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr;
  logic            sll_ok, sr_ok;

  assign inst    = bus.in_inst;
  assign opc     = inst[6:0];
  assign f3      = inst[14:12];
  assign f7      = inst[31:25];
  assign imm_i   = XLEN'($signed(inst[31:20]));
  assign imm_s   = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_csr = XLEN'(inst[31:20]);

  // At RV64, inst[25] belongs to the 6-bit shamt, so funct7 is checked on [31:26] only.
  assign sll_ok = RV64 ? (inst[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign sr_ok  = RV64 ? (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000)
                       : (f7 == 7'b0000000 || f7 == 7'b0100000);

  logic            bad, use_rd, use_rs1, use_rs2, word;
  logic [4:0]      alu;
  logic [10:0]     ctrl;
  logic [XLEN-1:0] imm;
  entry_t          dec;

  always_comb begin
    bad     = (inst[1:0] != 2'b11);
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    word    = 1'b0;
    alu     = ALU_ADD;
    ctrl    = '0;
    imm     = '0;
    case (opc)
      OPC_LUI:   begin use_rd = 1'b1; imm = imm_u; ctrl = C_IMM; end
      OPC_AUIPC: begin use_rd = 1'b1; imm = imm_u; ctrl = C_PC | C_IMM; end
      OPC_JAL:   begin use_rd = 1'b1; imm = imm_j; ctrl = C_JUMP; end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i; ctrl = C_JALR | C_IMM;
        if (f3 != 3'b000) bad = 1'b1;
      end
      OPC_BRANCH: begin
        // Branch-taken is "result zero" (C_BZ) or "result non-zero" on the compare result.
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b; ctrl = C_BR;
        case (f3)
          3'b000:  begin alu = ALU_SUB;  ctrl = C_BR | C_BZ; end
          3'b001:  alu = ALU_SUB;
          3'b100:  alu = ALU_SLT;
          3'b101:  begin alu = ALU_SLT;  ctrl = C_BR | C_BZ; end
          3'b110:  alu = ALU_SLTU;
          3'b111:  begin alu = ALU_SLTU; ctrl = C_BR | C_BZ; end
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i; ctrl = C_LOAD | C_IMM;
        if (f3 == 3'b111 || ((f3 == 3'b011 || f3 == 3'b110) && !RV64)) bad = 1'b1;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s; ctrl = C_STORE | C_IMM;
        if (f3[2] || (f3 == 3'b011 && !RV64)) bad = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i; ctrl = C_IMM;
        case (f3)
          3'b000: alu = ALU_ADD;
          3'b001: begin alu = ALU_SLL; if (!sll_ok) bad = 1'b1; end
          3'b010: alu = ALU_SLT;
          3'b011: alu = ALU_SLTU;
          3'b100: alu = ALU_XOR;
          3'b101: begin alu = inst[30] ? ALU_SRA : ALU_SRL; if (!sr_ok) bad = 1'b1; end
          3'b110: alu = ALU_OR;
          default: alu = ALU_AND;
        endcase
      end
      OPC_OP_IMM32: begin
        use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i; ctrl = C_IMM; word = 1'b1;
        case (f3)
          3'b000:  alu = ALU_ADD;
          3'b001:  begin alu = ALU_SLL; if (f7 != 7'b0000000) bad = 1'b1; end
          3'b101:  begin
            alu = inst[30] ? ALU_SRA : ALU_SRL;
            if (f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
        if (!RV64) bad = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; word = (opc == OPC_OP32);
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  alu = ALU_ADD;
              3'b001:  alu = ALU_SLL;
              3'b010:  alu = ALU_SLT;
              3'b011:  alu = ALU_SLTU;
              3'b100:  alu = ALU_XOR;
              3'b101:  alu = ALU_SRL;
              3'b110:  alu = ALU_OR;
              default: alu = ALU_AND;
            endcase
            if (word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) bad = 1'b1;
          end
          7'b0100000: begin
            alu = f3[2] ? ALU_SRA : ALU_SUB;
            if (f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
          end
          7'b0000001: begin
            alu = {2'b10, f3};
            if (!HAS_M) bad = 1'b1;
            if (word && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011)) bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
        if (word && !RV64) bad = 1'b1;
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        case (f3)
          3'b000: ;
          3'b100: bad = 1'b1;
          default: begin
            use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_csr;
            ctrl = f3[2] ? (C_CSR | C_CSRI) : C_CSR;
            if (f3[1]) ctrl = ctrl | C_CSRSC;
            alu = (f3[1:0] == 2'b10) ? ALU_OR : (f3[1:0] == 2'b11) ? ALU_AND : ALU_ADD;
          end
        endcase
      end
      default: bad = 1'b1;
    endcase

    dec.pc      = bus.in_pc;
    dec.illegal = bad;
    dec.rd      = (use_rd  && !bad) ? inst[11:7]  : 5'd0;
    dec.rs1     = (use_rs1 && !bad) ? inst[19:15] : 5'd0;
    dec.rs2     = (use_rs2 && !bad) ? inst[24:20] : 5'd0;
    dec.imm     = bad ? '0 : imm;
    dec.alu_op  = bad ? 5'd0 : alu;
    dec.word    = bad ? 1'b0 : word;
    dec.ctrl    = bad ? 11'd0 : ctrl;
  end

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            accept, pop;

  assign bus.in_ready  = (count != FULL) || bus.out_ready;
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop) count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.out_pc      = head.pc;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_imm     = head.imm;
  assign bus.out_alu_op  = head.alu_op;
  assign bus.out_word    = head.word;
  assign bus.out_ctrl    = head.ctrl;
  assign bus.out_illegal = head.illegal;
endmodule
